// File: rtl/uc_pkg.sv
// Shared opcode constants, control-word layout and FSM encoding for the
// microc sequencer.
package uc_pkg;

    localparam int unsigned OPC_W    = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned ICOUNT_W = 16;

    localparam logic [ICOUNT_W-1:0] ICOUNT_MAX = {ICOUNT_W{1'b1}};

    localparam logic [OPC_W-1:0] OP_J   = 6'b010000;
    localparam logic [OPC_W-1:0] OP_JZ  = 6'b010001;
    localparam logic [OPC_W-1:0] OP_JNZ = 6'b010010;

    // Instruction classes are recognised by (Opcode & MASK) == MATCH.
    localparam logic [OPC_W-1:0] ALU_MASK  = 6'b100000;
    localparam logic [OPC_W-1:0] ALU_MATCH = 6'b100000;
    localparam logic [OPC_W-1:0] LI_MASK   = 6'b111100;
    localparam logic [OPC_W-1:0] LI_MATCH  = 6'b000100;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LOOP1 = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    typedef struct packed {
        logic               s_inc;
        logic               s_inm;
        logic               we3;
        logic               wez;
        logic [ALUOP_W-1:0] op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0,
                                    wez: 1'b0, op: 3'b000};

    localparam ctrl_t CTRL_NOP  = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0,
                                    wez: 1'b0, op: 3'b000};

    function automatic logic opc_match(input logic [OPC_W-1:0] opc,
                                       input logic [OPC_W-1:0] mask,
                                       input logic [OPC_W-1:0] match);
        return (opc & mask) == match;
    endfunction

endpackage

// File: rtl/uc_dec.sv
// Pure combinational instruction decode: Opcode and zero flag to control word,
// plus class flags the sequencer needs for its loop detection and error flag.
module uc_dec
    import uc_pkg::*;
(
    input  logic [OPC_W-1:0] Opcode,
    input  logic             z,
    output ctrl_t            ctrl,
    output logic             is_j,
    output logic             undef
);

    always_comb begin
        ctrl  = CTRL_NOP;
        is_j  = 1'b0;
        undef = 1'b0;

        if (opc_match(Opcode, ALU_MASK, ALU_MATCH)) begin
            ctrl.op  = Opcode[4:2];
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
        end else if (opc_match(Opcode, LI_MASK, LI_MATCH)) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
        end else begin
            unique case (Opcode)
                OP_J: begin
                    ctrl.s_inc = 1'b0;
                    is_j       = 1'b1;
                end
                // s_inc=0 selects the branch target, so jz branches when z=1.
                OP_JZ:   ctrl.s_inc = ~z;
                OP_JNZ:  ctrl.s_inc = z;
                default: undef = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc_seq.sv
// Microc control sequencer: zero-latency decode with terminal-jump-loop
// detection, sticky illegal-opcode flag and saturating instruction counter.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | normal execution
//   ST_LOOP1 | previous instruction was j; a second j means a dead loop
//   ST_HALT  | dead loop seen; outputs idle, counter frozen until reset
module uc_seq
    import uc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPC_W-1:0]    Opcode,
    input  logic                z,
    output logic                s_inc,
    output logic                s_inm,
    output logic                we3,
    output logic                wez,
    output logic [ALUOP_W-1:0]  Op,
    output logic                halted,
    output logic                illegal,
    output logic [ICOUNT_W-1:0] icount
);

    ctrl_t                dec_ctrl;
    logic                 dec_is_j;
    logic                 dec_undef;
    ctrl_t                ctrl;

    state_t               state_q,   state_d;
    logic                 halted_q,  halted_d;
    logic                 illegal_q, illegal_d;
    logic [ICOUNT_W-1:0]  icount_q,  icount_d;
    logic                 executing;

    uc_dec u_dec (
        .Opcode (Opcode),
        .z      (z),
        .ctrl   (dec_ctrl),
        .is_j   (dec_is_j),
        .undef  (dec_undef)
    );

    always_comb begin
        state_d   = state_q;
        ctrl      = dec_ctrl;
        executing = 1'b0;

        case (state_q)
            ST_RUN: begin
                executing = 1'b1;
                if (dec_is_j) begin
                    state_d = ST_LOOP1;
                end
            end
            ST_LOOP1: begin
                executing = 1'b1;
                state_d   = dec_is_j ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                ctrl = CTRL_IDLE;
            end
            // Unreachable encoding: decode normally and recover to RUN.
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        halted_d  = (state_d == ST_HALT);
        illegal_d = illegal_q;
        icount_d  = icount_q;
        if (executing) begin
            if (dec_undef) begin
                illegal_d = 1'b1;
            end
            if (icount_q != ICOUNT_MAX) begin
                icount_d = icount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            icount_q  <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            icount_q  <= icount_d;
        end
    end

    assign s_inc   = ctrl.s_inc;
    assign s_inm   = ctrl.s_inm;
    assign we3     = ctrl.we3;
    assign wez     = ctrl.wez;
    assign Op      = ctrl.op;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign icount  = icount_q;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: an instruction-level model checked every cycle,
// plus hand-computed checkpoints along the program.
module tb_uc_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        z;
    logic        s_inc, s_inm, we3, wez;
    logic [2:0]  Op;
    logic        halted, illegal;
    logic [15:0] icount;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] I_LI  = 6'b000100;
    localparam logic [5:0] I_ADD = 6'b101000;
    localparam logic [5:0] I_SUB = 6'b101100;
    localparam logic [5:0] I_J   = 6'b010000;
    localparam logic [5:0] I_JZ  = 6'b010001;
    localparam logic [5:0] I_JNZ = 6'b010010;
    localparam logic [5:0] I_BAD = 6'b001100;

    uc_seq dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .z       (z),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .Op      (Op),
        .halted  (halted),
        .illegal (illegal),
        .icount  (icount)
    );

    always #5 clk = ~clk;

    // Instruction-level model: counts executed instructions, remembers whether
    // the last executed instruction was j, and stops once two j's run back to back.
    int m_icount  = 0;
    bit m_illegal = 1'b0;
    bit m_last_j  = 1'b0;
    bit m_halted  = 1'b0;

    function automatic bit is_defined(input logic [5:0] opc);
        int v;
        v = int'(opc);
        return (v >= 32) || (v >= 4 && v <= 7) || (v == 16) || (v == 17) || (v == 18);
    endfunction

    // Returns {s_inc, s_inm, we3, wez, Op}.
    function automatic logic [6:0] expect_ctrl(input logic [5:0] opc, input logic zv,
                                               input bit hlt);
        int v;
        v = int'(opc);
        if (hlt)                 return 7'b0000_000;
        if (v >= 32)             return {4'b1011, 3'((v / 4) % 8)};
        if (v >= 4 && v <= 7)    return 7'b1110_000;
        if (v == 16)             return 7'b0000_000;
        if (v == 17)             return {~zv, 6'b000_000};
        if (v == 18)             return {zv, 6'b000_000};
        return 7'b1000_000;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_icount  <= 0;
            m_illegal <= 1'b0;
            m_last_j  <= 1'b0;
            m_halted  <= 1'b0;
        end else if (!m_halted) begin
            m_icount <= (m_icount < 65535) ? m_icount + 1 : 65535;
            if (!is_defined(Opcode)) m_illegal <= 1'b1;
            if (Opcode == I_J) begin
                if (m_last_j) m_halted <= 1'b1;
                m_last_j <= 1'b1;
            end else begin
                m_last_j <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("ctrl_word", int'({s_inc, s_inm, we3, wez, Op}),
              int'(expect_ctrl(Opcode, z, m_halted)));
        check("reg_state", int'({halted, illegal, icount}),
              int'({m_halted, m_illegal, 16'(m_icount)}));
    end

    task automatic step(input logic [5:0] op, input logic zv);
        @(posedge clk);
        #2;
        Opcode = op;
        z      = zv;
    endtask

    int frozen;

    initial begin
        reset  = 1'b0;
        Opcode = I_LI;
        z      = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_halted", int'(halted), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_icount", int'(icount), 0);
        check("rst_decode_li", int'({s_inc, s_inm, we3, wez}), 4'b1110);

        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (3) step(I_LI, 1'b0);
        step(I_ADD, 1'b0); #1;
        check("li4_icount", int'(icount), 4);
        check("add_op", int'(Op), 3'b010);
        check("add_ctrl", int'({s_inm, we3, wez}), 3'b011);
        step(I_SUB, 1'b0); #1;
        check("sub_op", int'(Op), 3'b011);
        check("sub_icount", int'(icount), 5);
        step(I_JNZ, 1'b0); #1;
        check("jnz_z0", int'(s_inc), 0);
        check("alu2_icount", int'(icount), 6);
        step(I_JNZ, 1'b1); #1;
        check("jnz_z1", int'(s_inc), 1);
        step(I_JZ, 1'b0);  #1;
        check("jz_z0", int'(s_inc), 1);
        step(I_JZ, 1'b1);  #1;
        check("jz_z1", int'(s_inc), 0);
        check("jz_halted", int'(halted), 0);

        step(I_J, 1'b0);
        step(I_ADD, 1'b0);
        step(I_J, 1'b0);
        step(I_LI, 1'b0); #1;
        check("j_add_j_halted", int'(halted), 0);
        step(I_LI, 1'b0); #1;
        check("loop1_back_run", int'(halted), 0);

        step(I_BAD, 1'b0); #1;
        check("bad_nop_ctrl", int'({s_inc, s_inm, we3, wez, Op}), 7'b1000_000);
        check("bad_not_yet", int'(illegal), 0);
        step(I_LI, 1'b0); #1;
        check("illegal_set", int'(illegal), 1);
        step(I_LI, 1'b0); #1;
        check("illegal_sticky", int'(illegal), 1);

        step(I_J, 1'b0);
        step(I_J, 1'b0);
        step(I_ADD, 1'b0); #1;
        check("jj_halted", int'(halted), 1);
        check("halt_ctrl", int'({s_inc, we3, wez}), 0);
        frozen = int'(icount);
        step(I_ADD, 1'b0);
        step(I_LI, 1'b0); #1;
        check("halt_icount_frozen", int'(icount), frozen);
        check("halt_illegal_kept", int'(illegal), 1);

        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset  = 1'b1;
        Opcode = I_BAD;
        repeat (34) step(I_LI, 1'b0);
        step(I_J, 1'b0);
        step(I_J, 1'b0);
        step(I_ADD, 1'b0); #1;
        check("pre_rst_icount", int'(icount), 37);
        check("pre_rst_halted", int'(halted), 1);
        check("pre_rst_illegal", int'(illegal), 1);
        reset = 1'b0;
        #1;
        check("async_rst_regs", int'({halted, illegal, icount}), 0);
        check("async_rst_decode", int'({s_inc, s_inm, we3, wez, Op}), 7'b1011_010);

        @(posedge clk);
        #2;
        reset  = 1'b1;
        Opcode = I_LI;
        repeat (65540) step(I_LI, 1'b0);
        #1;
        check("sat_icount", int'(icount), 16'hFFFF);
        step(I_ADD, 1'b0); #1;
        check("sat_icount_held", int'(icount), 16'hFFFF);
        check("sat_halted", int'(halted), 0);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
